// File: rtl/seg7_mux_n.sv
// Multiplexed 7-segment driver: scans DIGITS digits, per-digit blink and decimal point,
// 16-level PWM brightness with one-cycle dead time between digit slots.
module seg7_mux_n #(
    parameter int DIGITS       = 4,
    parameter int DIV_LOG2     = 16,
    parameter int BLINK_FRAMES = 64
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [5*DIGITS-1:0]   dig_i,
    input  logic [DIGITS-1:0]     dp_i,
    input  logic [DIGITS-1:0]     blink_i,
    input  logic [3:0]            bright_i,
    input  logic                  en_i,
    output logic [DIGITS-1:0]     disp_o,
    output logic [7:0]            seg_o,
    output logic                  frame_o
);

    localparam int IDX_W = $clog2(DIGITS);
    localparam int FC_W  = 10;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);
    localparam logic [FC_W-1:0]  FC_LAST  = FC_W'(BLINK_FRAMES - 1);

    logic [DIV_LOG2-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [FC_W-1:0]     fcnt_q, fcnt_d;
    logic                blink_q, blink_d;
    logic                frame_q, frame_d;
    logic [DIGITS-1:0]   disp_q, disp_d;
    logic [7:0]          seg_q, seg_d;

    logic                tick;
    logic [3:0]          phase;
    logic [4:0]          code;
    logic                dp_sel;
    logic                blink_sel;
    logic [DIGITS-1:0]   onehot;
    logic [6:0]          glyph;
    logic                lit;

    always_comb begin
        tick  = &cnt_q;
        cnt_d = cnt_q + 1'b1;

        idx_d = idx_q;
        if (tick) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end
        frame_d = tick && (idx_q == IDX_LAST);

        // Blink timebase advances on the registered frame pulse, so it keeps running with en_i low.
        fcnt_d  = fcnt_q;
        blink_d = blink_q;
        if (frame_q) begin
            if (fcnt_q == FC_LAST) begin
                fcnt_d  = '0;
                blink_d = ~blink_q;
            end else begin
                fcnt_d = fcnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        code      = '0;
        dp_sel    = 1'b0;
        blink_sel = 1'b0;
        onehot    = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                code      = dig_i[5*i +: 5];
                dp_sel    = dp_i[i];
                blink_sel = blink_i[i];
                onehot[i] = 1'b1;
            end
        end

        // Active-low, bit order g..a.
        case (code)
            5'h00:   glyph = 7'b1000000;
            5'h01:   glyph = 7'b1111001;
            5'h02:   glyph = 7'b0100100;
            5'h03:   glyph = 7'b0110000;
            5'h04:   glyph = 7'b0011001;
            5'h05:   glyph = 7'b0010010;
            5'h06:   glyph = 7'b0000010;
            5'h07:   glyph = 7'b1111000;
            5'h08:   glyph = 7'b0000000;
            5'h09:   glyph = 7'b0010000;
            5'h0A:   glyph = 7'b0001000;
            5'h0B:   glyph = 7'b0000011;
            5'h0C:   glyph = 7'b1000110;
            5'h0D:   glyph = 7'b0100001;
            5'h0E:   glyph = 7'b0000110;
            5'h0F:   glyph = 7'b0001110;
            5'h11:   glyph = 7'b0111111;
            default: glyph = 7'b1111111;
        endcase

        phase  = cnt_q[DIV_LOG2-1 -: 4];
        lit    = en_i && (phase <= bright_i) && (cnt_q != '0) && !(blink_sel && blink_q);
        disp_d = lit ? onehot : '0;
        seg_d  = lit ? {~dp_sel, glyph} : 8'hFF;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q   <= '0;
            idx_q   <= '0;
            fcnt_q  <= '0;
            blink_q <= 1'b0;
            frame_q <= 1'b0;
            disp_q  <= '0;
            seg_q   <= 8'hFF;
        end else begin
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            fcnt_q  <= fcnt_d;
            blink_q <= blink_d;
            frame_q <= frame_d;
            disp_q  <= disp_d;
            seg_q   <= seg_d;
        end
    end

    assign disp_o  = disp_q;
    assign seg_o   = seg_q;
    assign frame_o = frame_q;

endmodule

// File: tb/tb_seg7_mux_n.sv
// Randomized bench for seg7_mux_n: 3-digit and 6-digit instances checked every cycle
// against a time-based model (slot, frame and blink phase derived from clocks since reset).
module tb_seg7_mux_n;

    localparam int DL2 = 4;
    localparam int BF  = 2;
    localparam int P   = 1 << DL2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [39:0] dig = '0;
    logic [7:0]  dp = '0;
    logic [7:0]  blink = '0;
    logic [3:0]  bright = 4'd15;
    logic        en = 1'b1;

    logic [2:0]  disp3;
    logic [7:0]  seg3;
    logic        fr3;
    logic [5:0]  disp6;
    logic [7:0]  seg6;
    logic        fr6;

    int     n_chk  = 0;
    int     n_pass = 0;
    longint k      = 0;

    always #5 clk = ~clk;

    seg7_mux_n #(.DIGITS(3), .DIV_LOG2(DL2), .BLINK_FRAMES(BF)) u_dut3 (
        .clk_i(clk), .rst_i(rst), .dig_i(dig[14:0]), .dp_i(dp[2:0]), .blink_i(blink[2:0]),
        .bright_i(bright), .en_i(en), .disp_o(disp3), .seg_o(seg3), .frame_o(fr3)
    );

    seg7_mux_n #(.DIGITS(6), .DIV_LOG2(DL2), .BLINK_FRAMES(BF)) u_dut6 (
        .clk_i(clk), .rst_i(rst), .dig_i(dig[29:0]), .dp_i(dp[5:0]), .blink_i(blink[5:0]),
        .bright_i(bright), .en_i(en), .disp_o(disp6), .seg_o(seg6), .frame_o(fr6)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, k);
    endtask

    // Segment letters lit for each code; converted to active-low g..a.
    function automatic logic [6:0] glyph(input logic [4:0] code);
        string s;
        logic [6:0] r;
        case (code)
            5'h00: s = "abcdef";   5'h01: s = "bc";      5'h02: s = "abdeg";  5'h03: s = "abcdg";
            5'h04: s = "bcfg";     5'h05: s = "acdfg";   5'h06: s = "acdefg"; 5'h07: s = "abc";
            5'h08: s = "abcdefg";  5'h09: s = "abcdfg";  5'h0A: s = "abcefg"; 5'h0B: s = "cdefg";
            5'h0C: s = "adef";     5'h0D: s = "bcdeg";   5'h0E: s = "adefg";  5'h0F: s = "aefg";
            5'h11: s = "g";
            default: s = "";
        endcase
        r = 7'h7F;
        for (int j = 0; j < s.len(); j++) r[s[j] - "a"] = 1'b0;
        return r;
    endfunction

    // kk = clocks elapsed since the last reset edge (state of the cycle being sampled).
    function automatic void model(input int n, input longint kk,
                                  output logic [7:0] dsp, output logic [7:0] sg, output logic fr);
        longint c, pulses;
        int     id;
        bit     bs, lit;
        c      = kk % P;
        id     = int'((kk / P) % n);
        pulses = (kk >= 1) ? (kk - 1) / (P * n) : 0;
        bs     = ((pulses / BF) % 2) == 1;
        lit    = en && ((c / (1 << (DL2 - 4))) <= bright) && (c != 0) && !(blink[id] && bs);
        dsp    = lit ? 8'(1 << id) : 8'h00;
        sg     = lit ? {~dp[id], glyph(dig[5*id +: 5])} : 8'hFF;
        fr     = ((kk + 1) % (P * n)) == 0;
    endfunction

    task automatic step();
        logic [7:0] e3d, e3s, e6d, e6s;
        logic       e3f, e6f;
        if (rst) begin
            e3d = 8'h00; e3s = 8'hFF; e3f = 1'b0;
            e6d = 8'h00; e6s = 8'hFF; e6f = 1'b0;
        end else begin
            model(3, k, e3d, e3s, e3f);
            model(6, k, e6d, e6s, e6f);
        end
        @(posedge clk);
        k = rst ? 0 : k + 1;
        @(negedge clk);
        check("disp3",  32'(disp3), 32'(e3d));
        check("seg3",   32'(seg3),  32'(e3s));
        check("frame3", 32'(fr3),   32'(e3f));
        check("disp6",  32'(disp6), 32'(e6d));
        check("seg6",   32'(seg6),  32'(e6s));
        check("frame6", 32'(fr6),   32'(e6f));
    endtask

    initial begin
        logic [4:0] codes [3];
        codes = '{5'h10, 5'h11, 5'h1F};
        repeat (2) @(negedge clk);
        repeat (3) step();
        rst = 1'b0;

        dig[14:0]  = {5'h08, 5'h01, 5'h00};
        dig[39:15] = 25'($urandom);
        repeat (150) step();

        blink = 8'b0000_0010;
        dp    = 8'b0000_0010;
        repeat (400) step();

        bright = 4'd0;  repeat (60) step();
        bright = 4'd7;  repeat (60) step();
        bright = 4'd15;
        blink  = '0;

        foreach (codes[i]) begin
            dig[4:0] = codes[i];
            repeat (48) step();
        end

        en = 1'b0; repeat (100) step();
        en = 1'b1;

        for (int i = 0; i < 48 && (k % 48) != 40; i++) step();
        rst = 1'b1; step();
        rst = 1'b0; repeat (60) step();

        repeat (2500) begin
            if ($urandom % 16 == 0) dig = {8'($urandom), 32'($urandom)};
            if ($urandom % 64 == 0) begin
                dp    = 8'($urandom);
                blink = 8'($urandom);
            end
            if ($urandom % 32 == 0) bright = 4'($urandom);
            if ($urandom % 40 == 0) en = ~en;
            rst = ($urandom % 700) == 0;
            step();
            rst = 1'b0;
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
